// File: rtl/wb_master_arbiter_pkg.sv
// Shared definitions for the two-master Wishbone arbiter: FSM state
// encodings, master identifiers and a grant-vector helper.
package wb_master_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_ABORT = 2'd2
  } arb_state_e;

  localparam logic MID_M0 = 1'b0;
  localparam logic MID_M1 = 1'b1;

  function automatic logic [1:0] grant_onehot(input logic id);
    return (id == MID_M1) ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/wb_bus_watchdog.sv
// Bus watchdog: counts stalled cycles while running and flags expiry in the
// cycle that would be the TIMEOUT_CYCLES-th consecutive unanswered one.
module wb_bus_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic i_clk,
  input  logic i_resetn,
  input  logic i_clear,
  input  logic i_run,
  output logic o_expired
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LIMIT   = CW'(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] PRE_LIM = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] r_count;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_run && (r_count != LIMIT)) begin
      r_count <= r_count + CW'(1);
    end
  end

  // The current cycle counts as stalled, so expiry is one below the limit.
  assign o_expired = i_run && (r_count >= PRE_LIM);

endmodule

// File: rtl/wb_master_arbiter.sv
// Round-robin arbiter granting whole Wishbone cycles to M0 (CPU) or M1
// (debug bridge), with a watchdog that aborts cycles the slave never answers.
module wb_master_arbiter
  import wb_master_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        i_clk,
  input  logic        i_resetn,

  input  logic        i_m0_wb_cyc,
  input  logic        i_m0_wb_stb,
  input  logic        i_m0_wb_we,
  input  logic [31:0] i_m0_wb_addr,
  input  logic [31:0] i_m0_wb_data,
  input  logic [3:0]  i_m0_wb_sel,
  output logic        o_m0_wb_ack,
  output logic        o_m0_wb_stall,
  output logic        o_m0_wb_err,
  output logic [31:0] o_m0_wb_data,

  input  logic        i_m1_wb_cyc,
  input  logic        i_m1_wb_stb,
  input  logic        i_m1_wb_we,
  input  logic [31:0] i_m1_wb_addr,
  input  logic [31:0] i_m1_wb_data,
  input  logic [3:0]  i_m1_wb_sel,
  output logic        o_m1_wb_ack,
  output logic        o_m1_wb_stall,
  output logic        o_m1_wb_err,
  output logic [31:0] o_m1_wb_data,

  output logic        o_wb_cyc,
  output logic        o_wb_stb,
  output logic        o_wb_we,
  output logic [31:0] o_wb_addr,
  output logic [31:0] o_wb_data,
  output logic [3:0]  o_wb_sel,
  input  logic        i_wb_ack,
  input  logic        i_wb_stall,
  input  logic        i_wb_err,
  input  logic [31:0] i_wb_data,

  output logic [1:0]  o_grant,
  output logic        o_timeout
);

  arb_state_e r_state;
  logic       r_owner;
  logic       r_last;
  logic [1:0] r_grant;

  logic w_busy;
  logic w_owner_cyc;
  logic w_owner_stb;
  logic w_any_req;
  logic w_pick;
  logic w_clear;
  logic w_run;
  logic w_expired;
  logic w_fwd;

  assign w_busy      = (r_state == ST_BUSY);
  assign w_owner_cyc = (r_owner == MID_M1) ? i_m1_wb_cyc : i_m0_wb_cyc;
  assign w_owner_stb = (r_owner == MID_M1) ? i_m1_wb_stb : i_m0_wb_stb;
  assign w_any_req   = i_m0_wb_cyc | i_m1_wb_cyc;
  assign w_pick      = (i_m0_wb_cyc && i_m1_wb_cyc) ? ~r_last : i_m1_wb_cyc;

  // Responses reach the owner only while it still holds cyc in BUSY, so an
  // ack arriving after the owner abandoned the cycle is swallowed.
  assign w_fwd   = w_busy && w_owner_cyc;
  assign w_run   = w_fwd && !i_wb_ack && !i_wb_err;
  assign w_clear = ((r_state == ST_IDLE) && w_any_req) || (w_busy && (i_wb_ack || i_wb_err));

  wb_bus_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .i_clk    (i_clk),
    .i_resetn (i_resetn),
    .i_clear  (w_clear),
    .i_run    (w_run),
    .o_expired(w_expired)
  );

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      r_state <= ST_IDLE;
      r_owner <= MID_M0;
      r_last  <= MID_M1;
      r_grant <= 2'b00;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any_req) begin
            r_state <= ST_BUSY;
            r_owner <= w_pick;
            r_last  <= w_pick;
            r_grant <= grant_onehot(w_pick);
          end
        end
        ST_BUSY: begin
          if (!w_owner_cyc) begin
            r_state <= ST_IDLE;
            r_grant <= 2'b00;
          end else if (w_expired) begin
            r_state <= ST_ABORT;
          end
        end
        ST_ABORT: begin
          if (!w_owner_cyc) begin
            r_state <= ST_IDLE;
            r_grant <= 2'b00;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_grant <= 2'b00;
        end
      endcase
    end
  end

  assign o_grant   = r_grant;
  assign o_timeout = w_fwd && w_expired;

  // Slave-side request path: zero-latency mux of the owner's signals.
  assign o_wb_cyc  = w_fwd;
  assign o_wb_stb  = w_fwd && w_owner_stb;
  assign o_wb_we   = (r_owner == MID_M1) ? i_m1_wb_we   : i_m0_wb_we;
  assign o_wb_addr = (r_owner == MID_M1) ? i_m1_wb_addr : i_m0_wb_addr;
  assign o_wb_data = (r_owner == MID_M1) ? i_m1_wb_data : i_m0_wb_data;
  assign o_wb_sel  = (r_owner == MID_M1) ? i_m1_wb_sel  : i_m0_wb_sel;

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    o_m0_wb_ack   = 1'b0;
    o_m0_wb_err   = 1'b0;
    o_m0_wb_stall = 1'b1;
    o_m0_wb_data  = 32'h0;
    o_m1_wb_ack   = 1'b0;
    o_m1_wb_err   = 1'b0;
    o_m1_wb_stall = 1'b1;
    o_m1_wb_data  = 32'h0;
    if (w_busy) begin
      if (r_owner == MID_M0) begin
        o_m0_wb_ack   = w_fwd && i_wb_ack;
        o_m0_wb_err   = w_fwd && (i_wb_err || w_expired);
        o_m0_wb_stall = i_wb_stall;
        o_m0_wb_data  = i_wb_data;
      end else begin
        o_m1_wb_ack   = w_fwd && i_wb_ack;
        o_m1_wb_err   = w_fwd && (i_wb_err || w_expired);
        o_m1_wb_stall = i_wb_stall;
        o_m1_wb_data  = i_wb_data;
      end
    end
  end

endmodule

// File: tb/tb_wb_master_arbiter.sv
// Directed testbench for wb_master_arbiter with TIMEOUT_CYCLES=8 and a
// hand-driven slave; expected values are written out per step.
module tb_wb_master_arbiter;

  logic        clk = 1'b0;
  logic        resetn;
  logic        m0_cyc, m0_stb, m0_we;
  logic [31:0] m0_addr, m0_wdat;
  logic [3:0]  m0_sel;
  logic        m0_ack, m0_stall, m0_err;
  logic [31:0] m0_rdat;
  logic        m1_cyc, m1_stb, m1_we;
  logic [31:0] m1_addr, m1_wdat;
  logic [3:0]  m1_sel;
  logic        m1_ack, m1_stall, m1_err;
  logic [31:0] m1_rdat;
  logic        wb_cyc, wb_stb, wb_we;
  logic [31:0] wb_addr, wb_wdat;
  logic [3:0]  wb_sel;
  logic        wb_ack, wb_stall, wb_err;
  logic [31:0] wb_rdat;
  logic [1:0]  grant;
  logic        timeout;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  wb_master_arbiter #(.TIMEOUT_CYCLES(8)) dut (
    .i_clk(clk), .i_resetn(resetn),
    .i_m0_wb_cyc(m0_cyc), .i_m0_wb_stb(m0_stb), .i_m0_wb_we(m0_we),
    .i_m0_wb_addr(m0_addr), .i_m0_wb_data(m0_wdat), .i_m0_wb_sel(m0_sel),
    .o_m0_wb_ack(m0_ack), .o_m0_wb_stall(m0_stall), .o_m0_wb_err(m0_err),
    .o_m0_wb_data(m0_rdat),
    .i_m1_wb_cyc(m1_cyc), .i_m1_wb_stb(m1_stb), .i_m1_wb_we(m1_we),
    .i_m1_wb_addr(m1_addr), .i_m1_wb_data(m1_wdat), .i_m1_wb_sel(m1_sel),
    .o_m1_wb_ack(m1_ack), .o_m1_wb_stall(m1_stall), .o_m1_wb_err(m1_err),
    .o_m1_wb_data(m1_rdat),
    .o_wb_cyc(wb_cyc), .o_wb_stb(wb_stb), .o_wb_we(wb_we),
    .o_wb_addr(wb_addr), .o_wb_data(wb_wdat), .o_wb_sel(wb_sel),
    .i_wb_ack(wb_ack), .i_wb_stall(wb_stall), .i_wb_err(wb_err),
    .i_wb_data(wb_rdat),
    .o_grant(grant), .o_timeout(timeout)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance to just after the next rising edge; inputs change here and
  // outputs are sampled #1 later, well clear of either edge.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    resetn = 1'b0;
    {m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we} = '0;
    m0_addr = '0; m0_wdat = '0; m0_sel = 4'hF;
    m1_addr = 32'hAAAA_0000; m1_wdat = 32'h5555_5555; m1_sel = 4'h3;
    wb_ack = 1'b0; wb_stall = 1'b0; wb_err = 1'b0; wb_rdat = 32'h0;

    // Reset state
    #12;
    check("rst_grant", 32'(grant), 32'h0);
    check("rst_cyc", 32'(wb_cyc), 32'h0);
    check("rst_m0_stall", 32'(m0_stall), 32'h1);
    check("rst_m1_stall", 32'(m1_stall), 32'h1);
    check("rst_timeout", 32'(timeout), 32'h0);
    resetn = 1'b1;

    // Tie out of reset: M0 first, M1 two cycles after M0 releases
    step(); m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1;
    settle(); check("tie_idle_grant", 32'(grant), 32'h0);
    step(); settle(); check("tie_grant_m0", 32'(grant), 32'h1);
    check("tie_m1_stall", 32'(m1_stall), 32'h1);
    m0_cyc = 0; m0_stb = 0;
    settle(); check("tie_release_cyc", 32'(wb_cyc), 32'h0);
    step(); settle(); check("tie_dead_cycle", 32'(grant), 32'h0);
    step(); settle(); check("tie_grant_m1", 32'(grant), 32'h2);
    check("tie_m1_cyc_fwd", 32'(wb_addr), 32'hAAAA_0000);
    m1_cyc = 0; m1_stb = 0;
    step(); m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1;
    step(); settle(); check("tie2_grant_m0", 32'(grant), 32'h1);
    m0_cyc = 0; m0_stb = 0; m1_cyc = 0; m1_stb = 0;
    step(); step();

    // Single read by M0, slave acks two cycles after stb
    m0_cyc = 1; m0_stb = 1; m0_we = 0; m0_addr = 32'h8000_0010;
    step(); settle();
    check("rd_grant", 32'(grant), 32'h1);
    check("rd_cyc", 32'(wb_cyc), 32'h1);
    check("rd_stb", 32'(wb_stb), 32'h1);
    check("rd_addr", wb_addr, 32'h8000_0010);
    check("rd_m1_stall_a", 32'(m1_stall), 32'h1);
    step(); m0_stb = 0;
    settle(); check("rd_stb_low", 32'(wb_stb), 32'h0);
    check("rd_m1_stall_b", 32'(m1_stall), 32'h1);
    step(); wb_ack = 1; wb_rdat = 32'h1234_5678;
    settle();
    check("rd_m0_ack", 32'(m0_ack), 32'h1);
    check("rd_m0_data", m0_rdat, 32'h1234_5678);
    check("rd_m1_ack", 32'(m1_ack), 32'h0);
    check("rd_m1_data", m1_rdat, 32'h0);
    check("rd_m1_stall_c", 32'(m1_stall), 32'h1);
    step(); wb_ack = 0; wb_rdat = 0; m0_cyc = 0;
    step(); settle(); check("rd_idle", 32'(grant), 32'h0);

    // Burst of four writes held under one cyc while M1 waits
    m0_cyc = 1; m0_stb = 1; m0_we = 1; m0_addr = 32'h100; m0_wdat = 32'hD0;
    step(); m1_cyc = 1; m1_stb = 1;
    for (int i = 0; i < 4; i++) begin
      m0_addr = 32'h100 + 32'(4 * i);
      m0_wdat = 32'hD0 + 32'(i);
      wb_ack  = 1;
      settle();
      check("bw_grant", 32'(grant), 32'h1);
      check("bw_addr", wb_addr, 32'h100 + 32'(4 * i));
      check("bw_data", wb_wdat, 32'hD0 + 32'(i));
      check("bw_we", 32'(wb_we), 32'h1);
      check("bw_m0_ack", 32'(m0_ack), 32'h1);
      step();
    end
    wb_ack = 0; m0_stb = 0; m0_cyc = 0; m0_we = 0;
    settle(); check("bw_hold_last", 32'(grant), 32'h1);
    step(); settle(); check("bw_dead", 32'(grant), 32'h0);
    step(); settle(); check("bw_m1_grant", 32'(grant), 32'h2);
    m1_cyc = 0; m1_stb = 0;
    step(); step();

    // Timeout: slave stalls forever, err/timeout on the 8th BUSY cycle
    m0_cyc = 1; m0_stb = 1; wb_stall = 1;
    for (int i = 1; i <= 8; i++) begin
      step(); settle();
      check("to_timeout", 32'(timeout), (i == 8) ? 32'h1 : 32'h0);
      check("to_m0_err", 32'(m0_err), (i == 8) ? 32'h1 : 32'h0);
      check("to_cyc", 32'(wb_cyc), 32'h1);
    end
    step(); wb_ack = 1;
    settle();
    check("ab_cyc", 32'(wb_cyc), 32'h0);
    check("ab_stb", 32'(wb_stb), 32'h0);
    check("ab_timeout", 32'(timeout), 32'h0);
    check("ab_err", 32'(m0_err), 32'h0);
    check("ab_late_ack", 32'(m0_ack), 32'h0);
    check("ab_stall", 32'(m0_stall), 32'h1);
    check("ab_grant", 32'(grant), 32'h1);
    step(); wb_ack = 0; m0_cyc = 0; m0_stb = 0;
    step(); settle(); check("ab_idle", 32'(grant), 32'h0);

    // Ack arriving on count 8 beats the watchdog
    m0_cyc = 1; m0_stb = 1;
    for (int i = 1; i <= 8; i++) begin
      step();
      wb_ack = (i == 8);
      settle();
      check("race_timeout", 32'(timeout), 32'h0);
      check("race_err", 32'(m0_err), 32'h0);
    end
    check("race_ack", 32'(m0_ack), 32'h1);
    step(); wb_ack = 0;
    settle();
    check("race_still_busy", 32'(wb_cyc), 32'h1);
    check("race_no_to_after", 32'(timeout), 32'h0);
    m0_cyc = 0; m0_stb = 0; wb_stall = 0;
    step(); step();

    // Asynchronous reset while M1 owns the bus
    m1_cyc = 1; m1_stb = 1;
    step(); settle(); check("rm_grant_m1", 32'(grant), 32'h2);
    wb_ack = 1; wb_rdat = 32'hCAFE_F00D;
    settle(); check("rm_m1_data_pre", m1_rdat, 32'hCAFE_F00D);
    resetn = 1'b0;
    #1;
    check("rm_grant", 32'(grant), 32'h0);
    check("rm_cyc", 32'(wb_cyc), 32'h0);
    check("rm_stb", 32'(wb_stb), 32'h0);
    check("rm_m1_ack", 32'(m1_ack), 32'h0);
    check("rm_m1_stall", 32'(m1_stall), 32'h1);
    check("rm_m1_data", m1_rdat, 32'h0);
    check("rm_timeout", 32'(timeout), 32'h0);
    wb_ack = 0; wb_rdat = 0;
    step(); resetn = 1'b1;
    m0_cyc = 1; m0_stb = 1;
    step(); settle(); check("rm_tie_m0", 32'(grant), 32'h1);
    m0_cyc = 0; m0_stb = 0; m1_cyc = 0; m1_stb = 0;
    step(); step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
